// File: rtl/inst_loader.sv
// Byte-stream instruction loader: packs byte pairs into 9-bit words and writes them
// sequentially into instruction storage, stopping on halt word, full memory or framing error.
`timescale 1ns/1ps
module inst_loader #(
    parameter int unsigned   AW        = 11,
    parameter int unsigned   DW        = 9,
    parameter logic [DW-1:0] HALT_WORD = 9'h1FF
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [7:0]    ByteIn,
    input  logic          ByteValid,
    output logic          ByteReady,
    output logic          WrEn,
    output logic [AW-1:0] WrAddr,
    output logic [DW-1:0] WrData,
    output logic          Loading,
    output logic          Done,
    output logic          Error,
    output logic          Full,
    output logic [AW:0]   WordCount
);

    typedef enum logic [2:0] {StIdle, StLo, StHi, StWrite, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] word_q, word_d;
    logic [AW:0]   count_q, count_d;
    logic          error_q, error_d;
    logic          full_q, full_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            word_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            count_q <= count_d;
            error_q <= error_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        word_d    = word_q;
        count_d   = count_q;
        error_d   = error_q;
        full_d    = full_q;
        ByteReady = 1'b0;
        WrEn      = 1'b0;
        Loading   = 1'b0;
        Done      = 1'b0;

        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StLo;
                    addr_d  = '0;
                    count_d = '0;
                    error_d = 1'b0;
                    full_d  = 1'b0;
                end
            end
            StLo: begin
                ByteReady = 1'b1;
                Loading   = 1'b1;
                if (ByteValid) begin
                    word_d  = DW'(ByteIn);
                    state_d = StHi;
                end
            end
            StHi: begin
                ByteReady = 1'b1;
                Loading   = 1'b1;
                if (ByteValid) begin
                    // Only bit 0 of the high byte is meaningful; anything else is a framing error
                    if (|ByteIn[7:1]) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        word_d[8] = ByteIn[0];
                        state_d   = StWrite;
                    end
                end
            end
            StWrite: begin
                WrEn    = 1'b1;
                Loading = 1'b1;
                count_d = count_q + 1'b1;
                if (word_q == HALT_WORD) begin
                    state_d = StDone;
                end else if (addr_q == '1) begin
                    full_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = StLo;
                end
            end
            StDone: begin
                Done = 1'b1;
                if (Start) begin
                    state_d = StLo;
                    addr_d  = '0;
                    count_d = '0;
                    error_d = 1'b0;
                    full_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign WrAddr    = addr_q;
    assign WrData    = word_q;
    assign Error     = error_q;
    assign Full      = full_q;
    assign WordCount = count_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: a stream-level model queues expected writes,
// a negedge monitor pops and compares every WrEn beat.
`timescale 1ns/1ps
module tb_inst_loader;

    localparam int AW = 11;
    localparam int DW = 9;

    typedef logic [7:0] bq_t[$];

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic [7:0]    ByteIn = 8'h00;
    logic          ByteValid = 1'b0;
    logic          ByteReady;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [DW-1:0] WrData;
    logic          Loading;
    logic          Done;
    logic          Error;
    logic          Full;
    logic [AW:0]   WordCount;

    inst_loader #(.AW(AW), .DW(DW), .HALT_WORD(9'h1FF)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .Loading   (Loading),
        .Done      (Done),
        .Error     (Error),
        .Full      (Full),
        .WordCount (WordCount)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int exp_addr[$];
    int exp_data[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write
    always @(negedge Clk) begin
        int a;
        int d;
        if (Reset_n && WrEn) begin
            if (exp_addr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                         WrAddr, WrData);
            end else begin
                a = exp_addr.pop_front();
                d = exp_data.pop_front();
                check("wr_addr", int'(WrAddr), a);
                check("wr_data", int'(WrData), d);
            end
            check("wren_while_ready", int'(ByteReady), 0);
        end
    end

    // Reference model over the whole byte stream; queues expected writes
    function automatic void model(input bq_t b, output int nacc, output int err,
                                  output int full, output int cnt);
        int lo;
        int hi;
        int w;
        nacc = 0; err = 0; full = 0; cnt = 0;
        for (int k = 0; 2 * k + 1 < b.size(); k++) begin
            lo = int'(b[2*k]);
            hi = int'(b[2*k+1]);
            nacc = 2 * k + 2;
            if (hi > 1) begin
                err = 1;
                return;
            end
            w = hi * 256 + lo;
            exp_addr.push_back(k);
            exp_data.push_back(w);
            cnt++;
            if (w == 511) return;
            if (k == (1 << AW) - 1) begin
                full = 1;
                return;
            end
        end
        nacc = b.size();
    endfunction

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic send(input bq_t b, input int from, input int to, input int gapmax);
        int guard;
        for (int i = from; i < to; i++) begin
            repeat ($urandom_range(gapmax, 0)) begin
                ByteValid = 1'b0;
                ByteIn    = 8'($urandom);
                @(posedge Clk); #1;
            end
            ByteValid = 1'b1;
            ByteIn    = b[i];
            guard = 0;
            while (!ByteReady && guard < 20) begin
                @(posedge Clk); #1;
                guard++;
            end
            if (!ByteReady) begin
                tests++;
                fails++;
                $display("FAIL byte_ready_timeout: byte %0d never accepted", i);
                ByteValid = 1'b0;
                return;
            end
            @(posedge Clk); #1;
        end
        ByteValid = 1'b0;
    endtask

    task automatic finish_load(input string name, input int err, input int full, input int cnt);
        int guard = 0;
        while (!Done && guard < 100) begin
            @(posedge Clk); #1;
            guard++;
        end
        check({name, "_done"}, int'(Done), 1);
        check({name, "_error"}, int'(Error), err);
        check({name, "_full"}, int'(Full), full);
        check({name, "_count"}, int'(WordCount), cnt);
        check({name, "_ready"}, int'(ByteReady), 0);
        check({name, "_loading"}, int'(Loading), 0);
        check({name, "_pending"}, exp_addr.size(), 0);
    endtask

    task automatic run_load(input string name, input bq_t b, input int gapmax);
        int nacc, err, full, cnt;
        model(b, nacc, err, full, cnt);
        pulse_start();
        send(b, 0, nacc, gapmax);
        finish_load(name, err, full, cnt);
    endtask

    task automatic check_zero(input string name);
        check({name, "_ready"}, int'(ByteReady), 0);
        check({name, "_wren"}, int'(WrEn), 0);
        check({name, "_addr"}, int'(WrAddr), 0);
        check({name, "_data"}, int'(WrData), 0);
        check({name, "_flags"}, int'({Loading, Done, Error, Full}), 0);
        check({name, "_count"}, int'(WordCount), 0);
    endtask

    initial begin
        bq_t b;
        int nacc, err, full, cnt;

        #1;
        check_zero("reset");
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(posedge Clk); #1;
        check_zero("idle");

        b = '{8'h01, 8'h00, 8'h49, 8'h00, 8'hFF, 8'h01};
        run_load("basic", b, 0);
        run_load("gaps", b, 4);

        b = '{8'h12, 8'h00, 8'h34, 8'h02};
        run_load("frame_err", b, 1);

        // Restart after error: flags cleared, addressing restarts at 0
        b = '{8'h0A, 8'h00, 8'hFF, 8'h01};
        model(b, nacc, err, full, cnt);
        pulse_start();
        check("restart_error_clr", int'(Error), 0);
        check("restart_done_clr", int'(Done), 0);
        check("restart_count_clr", int'(WordCount), 0);
        send(b, 0, nacc, 0);
        finish_load("restart", err, full, cnt);

        for (int t = 0; t < 6; t++) begin
            int n = $urandom_range(20, 1);
            b = {};
            for (int k = 0; k < n; k++) begin
                b.push_back(8'($urandom));
                if ($urandom_range(15, 0) == 0) b.push_back(8'($urandom_range(255, 2)));
                else b.push_back(8'($urandom_range(1, 0)));
            end
            b.push_back(8'hFF);
            b.push_back(8'h01);
            run_load("random", b, 3);
        end

        // Start pulses inside HI and WRITE must be ignored
        b = '{8'h11, 8'h00, 8'h22, 8'h01, 8'h33, 8'h00, 8'hFF, 8'h01};
        model(b, nacc, err, full, cnt);
        pulse_start();
        send(b, 0, 3, 0);
        pulse_start();
        send(b, 3, 4, 0);
        pulse_start();
        send(b, 4, nacc, 1);
        finish_load("start_ignored", err, full, cnt);

        b = {};
        repeat (2 * (1 << AW)) b.push_back(8'h00);
        run_load("full", b, 0);
        ByteValid = 1'b1;
        ByteIn    = 8'h00;
        repeat (5) begin
            check("full_ready_low", int'(ByteReady), 0);
            @(posedge Clk); #1;
        end
        ByteValid = 1'b0;
        check("full_count_hold", int'(WordCount), 1 << AW);

        b = {};
        repeat (2 * ((1 << AW) - 1)) b.push_back(8'h00);
        b.push_back(8'hFF);
        b.push_back(8'h01);
        run_load("halt_last", b, 0);

        // Reset in the middle of a word
        b = '{8'h05, 8'h00, 8'h07};
        model(b, nacc, err, full, cnt);
        pulse_start();
        send(b, 0, nacc, 0);
        Reset_n = 1'b0;
        #1;
        check_zero("mid_reset");
        check("mid_reset_pending", exp_addr.size(), 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        b = '{8'h09, 8'h01, 8'hFF, 8'h01};
        run_load("after_reset", b, 2);

        repeat (3) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction memory: receives a program as an 8-bit byte stream over a valid/ready handshake.
- Packs each pair of bytes into a 9-bit instruction word and issues one write per word into instruction storage, at sequential addresses starting from 0.
- Replaces file-based preload for bring-up and on-board program download.
- Ends the load on a halt word, on a full memory, or on a framing error.

Parameters:
AW, 11, instruction address width (2^AW words of storage)
DW, 9, instruction word width
HALT_WORD, 9'h1FF, instruction value that terminates the load (it is still written)

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset_n  input  1  asynchronous active-low reset
Start  input  1  single-cycle pulse that begins a load
ByteIn  input  8  stream byte
ByteValid  input  1  ByteIn is valid this cycle
ByteReady  output  1  loader accepts ByteIn this cycle
WrEn  output  1  write strobe to instruction storage, one cycle per word
WrAddr  output  AW  write address
WrData  output  DW  write data
Loading  output  1  load in progress
Done  output  1  load finished; held until next Start
Error  output  1  framing error terminated the load
Full  output  1  storage filled without a halt word
WordCount  output  AW+1  words written in current/last load

Behaviour:
- Reset (Reset_n=0, asynchronous): state IDLE. All outputs 0: ByteReady, WrEn, WrAddr, WrData, Loading, Done, Error, Full, WordCount. Takes effect mid-load; the partially assembled word is discarded and no write is issued.
- A byte is accepted only on a cycle with ByteValid=1 and ByteReady=1.
- States:
  - IDLE: ByteReady=0. Start -> LO; clear address, WordCount and all flags.
  - LO: ByteReady=1, Loading=1. On accept, latch ByteIn as word bits [7:0] -> HI.
  - HI: ByteReady=1, Loading=1. On accept:
    - If ByteIn[7:1] != 0: set Error -> DONE; no write, WordCount unchanged.
    - Otherwise word bit 8 = ByteIn[0] -> WRITE.
  - WRITE: ByteReady=0. WrEn=1 for exactly this cycle, with WrAddr = current address and WrData = assembled word. WordCount increments at the end of the cycle. Then:
    - If word == HALT_WORD -> DONE.
    - Else if address == 2^AW-1: set Full -> DONE.
    - Else address+1 -> LO.
  - DONE: ByteReady=0, Loading=0, Done=1. Start -> LO, clearing flags, count and address.
- Timing:
  - WrEn asserts in the cycle after the high byte is accepted.
  - Minimum 3 cycles per word.
  - WrAddr/WrData are registered and stable while WrEn=1.
- Start in LO, HI or WRITE is ignored. Start coincident with reset release is ignored.
- The address never wraps; the Full check precedes any increment past 2^AW-1.
- WordCount saturates naturally at 2^AW; its width holds that value.
- A halt word in the last location sets Done only; Full stays 0.
- Error, Full and halt are mutually exclusive for a given load.
- ByteIn is ignored whenever ByteReady=0; no byte is lost or double-counted under arbitrary ByteValid gaps.

Test Plan:
- Start, then bytes 01,00,49,00,FF,01 with back-to-back valid -> WrEn pulses writing addr0=0x001, addr1=0x049, addr2=0x1FF; Done=1, WordCount=3, Error=0, Full=0, ByteReady=0 afterwards.
- Same stream with ByteValid randomly deasserted 0-4 cycles between bytes -> identical writes and ordering; WrEn never asserts while in LO/HI.
- Start, bytes 12,00,34,02 -> one write (addr0=0x012); Error=1, Done=1, WordCount=1, no write for 0x034.
- Start, 2048 words of 0x000 -> last write at addr 2047; Full=1, Done=1, WordCount=2048; further valid bytes not accepted (ByteReady=0).
- Start, bytes 05,00,07; assert Reset_n=0 mid-stream -> all outputs 0 immediately, no WrEn. Release reset, Start, 09,01,FF,01 -> writes addr0=0x109, addr1=0x1FF, WordCount=2.
- Start pulsed again during a load -> ignored, addresses continue. Start in DONE after an Error -> Error cleared, next word written at addr0.
